// File: rtl/uart_rx_os_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_os_pkg : shared types and entry layout for uart_rx_os        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_rx_os_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_t;

  // FIFO entry = {data, break, frame_err, parity_err}; flags sit in the low bits.
  localparam int ENT_PERR  = 0;
  localparam int ENT_FERR  = 1;
  localparam int ENT_BRK   = 2;
  localparam int ENT_FLAGS = 3;

  function automatic parity_mode_t decode_parity(input logic [1:0] mode);
    return (mode == 2'b11) ? PAR_NONE : parity_mode_t'(mode);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_sync_fifo : synchronous show-ahead FIFO, power-of-two depth  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_os : oversampling UART receiver with majority vote and FIFO  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [15:0]                   baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          rd_break,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int EW = DATA_BITS + ENT_FLAGS;
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  logic                 rx_meta_q, rxs_q;
  logic [15:0]          presc_q, presc_d;
  logic [15:0]          div_q;
  rx_state_t            state_q;
  logic [SW-1:0]        sub_q;
  logic [3:0]           bit_q;
  logic [1:0]           vote_q;
  logic [DATA_BITS-1:0] shift_q;
  parity_mode_t         par_q;
  logic                 two_stop_q;
  logic                 perr_q, ferr_q, par_bit_q;
  logic                 stop_idx_q, first_stop_zero_q;
  logic                 push_q;
  logic [EW-1:0]        entry_q;
  logic                 overrun_q;

  logic                 w_tick, w_maj, w_par_en, w_last_stop;
  logic                 w_first_zero, w_break, w_ferr;
  logic [15:0]          w_div;
  logic [EW-1:0]        w_head;
  logic                 w_full, w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Live divisor only while hunting for a start bit; the latched copy governs a frame.
  assign w_div   = (state_q == ST_IDLE) ? baud_div : div_q;
  assign w_tick  = (presc_q >= w_div);
  assign presc_d = w_tick ? '0 : presc_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  assign w_maj        = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
  assign w_par_en     = (par_q != PAR_NONE);
  assign w_last_stop  = (stop_idx_q == two_stop_q);
  assign w_first_zero = stop_idx_q ? first_stop_zero_q : ~w_maj;
  assign w_break      = (shift_q == '0) && !(w_par_en && par_bit_q) && w_first_zero;
  assign w_ferr       = ferr_q | ~w_maj;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      sub_q             <= '0;
      bit_q             <= '0;
      vote_q            <= '0;
      shift_q           <= '0;
      par_q             <= PAR_NONE;
      two_stop_q        <= 1'b0;
      div_q             <= '0;
      perr_q            <= 1'b0;
      ferr_q            <= 1'b0;
      par_bit_q         <= 1'b0;
      stop_idx_q        <= 1'b0;
      first_stop_zero_q <= 1'b0;
      push_q            <= 1'b0;
      entry_q           <= '0;
    end else begin
      push_q <= 1'b0;
      if (w_tick) begin
        if (state_q != ST_IDLE && state_q != ST_BREAK_WAIT)
          sub_q <= (sub_q == S_LAST) ? '0 : sub_q + 1'b1;
        if (sub_q == S_LO)  vote_q[0] <= rxs_q;
        if (sub_q == S_MID) vote_q[1] <= rxs_q;
        unique case (state_q)
          ST_IDLE: begin
            if (!rxs_q) begin
              // The detecting tick counts as sample 0 of the start bit.
              state_q    <= ST_START;
              sub_q      <= SW'(1);
              par_q      <= decode_parity(parity_mode);
              two_stop_q <= two_stop;
              div_q      <= baud_div;
              bit_q      <= '0;
              perr_q     <= 1'b0;
              ferr_q     <= 1'b0;
              par_bit_q  <= 1'b0;
              stop_idx_q <= 1'b0;
            end
          end
          ST_START: begin
            if (sub_q == S_HI && w_maj) state_q <= ST_IDLE;
            else if (sub_q == S_LAST)   state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (sub_q == S_HI) shift_q <= {w_maj, shift_q[DATA_BITS-1:1]};
            if (sub_q == S_LAST) begin
              if (bit_q == 4'(DATA_BITS - 1)) state_q <= w_par_en ? ST_PARITY : ST_STOP;
              else                            bit_q   <= bit_q + 1'b1;
            end
          end
          ST_PARITY: begin
            if (sub_q == S_HI) begin
              par_bit_q <= w_maj;
              perr_q    <= w_maj ^ (^shift_q) ^ (par_q == PAR_ODD);
            end
            if (sub_q == S_LAST) state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (sub_q == S_HI) begin
              ferr_q <= w_ferr;
              if (!stop_idx_q) first_stop_zero_q <= ~w_maj;
              if (w_last_stop) begin
                push_q  <= 1'b1;
                entry_q <= w_break ? {{DATA_BITS{1'b0}}, 3'b110}
                                   : {shift_q, 1'b0, w_ferr, perr_q};
                state_q <= w_break ? ST_BREAK_WAIT : ST_IDLE;
              end
            end else if (sub_q == S_LAST) begin
              stop_idx_q <= 1'b1;
            end
          end
          ST_BREAK_WAIT: begin
            if (rxs_q) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .data_i  (entry_q),
    .pop_i   (rd_ready),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (fifo_level)
  );

  // A fresh overrun beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                                overrun_q <= 1'b0;
    else if (push_q && w_full && !rd_ready) overrun_q <= 1'b1;
    else if (overrun_clr)                   overrun_q <= 1'b0;
  end

  assign overrun       = overrun_q;
  assign rd_valid      = !w_empty;
  assign rd_data       = w_head[EW-1:ENT_FLAGS];
  assign rd_break      = w_head[ENT_BRK];
  assign rd_frame_err  = w_head[ENT_FERR];
  assign rd_parity_err = w_head[ENT_PERR];

endmodule
`default_nettype wire
